iir_lowpass_mc: RTL

Multi-channel, time-multiplexed first-order IIR low-pass filter, y[n] = (1−α)·y[n−1] + α·x[n], on a valid/ready stream of signed fixed-point samples tagged with a channel index. It keeps one filter state per channel and takes α from a runtime-loadable register. It adds round-to-nearest, per-channel state clear, bypass, and full backpressure through a two-stage pipeline. It sits between the sample source and downstream consumers, in the same place the single-channel RC low-pass occupied.

---
 rtl/iir_lowpass_mc.sv | 129 ++++++++++++
 1 files changed

// File: rtl/iir_lowpass_mc.sv
// Time-multiplexed first-order IIR low-pass, y = (1-a)*y[n-1] + a*x, one state per channel.
// Two-stage valid/ready pipeline: stage A holds the accepted sample, stage Y the filtered result.
module iir_lowpass_mc #(
   parameter int W             = 16,
   parameter int W_FRAC        = 8,
   parameter int CHANNELS      = 4,
   parameter int CW            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   parameter int ALPHA_DEFAULT = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [W-1:0]         alpha_data,
   input  logic                 alpha_load,
   input  logic                 clear_valid,
   input  logic [CW-1:0]        clear_chan,
   input  logic                 bypass,
   input  logic signed [W-1:0]  x_data,
   input  logic [CW-1:0]        x_chan,
   input  logic                 x_valid,
   output logic                 x_ready,
   output logic signed [W-1:0]  y_data,
   output logic [CW-1:0]        y_chan,
   output logic                 y_valid,
   input  logic                 y_ready
);

   localparam int                     PW   = 2 * W + 2;
   localparam logic [W-1:0]           ONE  = W'(1 << W_FRAC);
   localparam logic signed [PW-1:0]   HALF = PW'(1 << (W_FRAC - 1));

   function automatic logic [W-1:0] clamp_alpha(input logic [W-1:0] a);
      return (a > ONE) ? ONE : a;
   endfunction

   function automatic logic signed [W-1:0] round_q(input logic signed [PW-1:0] p);
      return W'((p + HALF) >>> W_FRAC);
   endfunction

   logic [W-1:0]         alpha_q, alpha_d;
   logic                 vld_p0_q, vld_p0_d;
   logic signed [W-1:0]  x_p0_q, x_p0_d;
   logic [CW-1:0]        chan_p0_q, chan_p0_d;
   logic [W-1:0]         alpha_p0_q, alpha_p0_d;
   logic                 byp_p0_q, byp_p0_d;
   logic                 vld_p1_q, vld_p1_d;
   logic signed [W-1:0]  y_p1_q, y_p1_d;
   logic [CW-1:0]        chan_p1_q, chan_p1_d;
   logic signed [W-1:0]  state_q [CHANNELS];
   logic signed [W-1:0]  state_d [CHANNELS];

   logic                 advance, accept, chan_ok;
   logic signed [W-1:0]  s, y_res;
   logic signed [PW-1:0] ka_s, kb_s, p;

   // Stage A -> filter arithmetic (the product is exact, so the result stays within the inputs' range)
   always_comb begin
      s       = '0;
      chan_ok = (int'(chan_p0_q) < CHANNELS);
      for (int c = 0; c < CHANNELS; c++) begin
         if (chan_p0_q == CW'(c)) s = state_q[c];
      end
      ka_s  = PW'(alpha_p0_q);
      kb_s  = PW'(ONE - alpha_p0_q);
      p     = ka_s * PW'(x_p0_q) + kb_s * PW'(s);
      y_res = (byp_p0_q || !chan_ok) ? x_p0_q : round_q(p);
   end

   always_comb begin
      advance    = vld_p0_q && (!vld_p1_q || y_ready);
      x_ready    = !vld_p0_q || advance;
      accept     = x_valid && x_ready;
      alpha_d    = alpha_load ? clamp_alpha(alpha_data) : alpha_q;
      vld_p0_d   = accept || (vld_p0_q && !advance);
      vld_p1_d   = advance || (vld_p1_q && !y_ready);
      x_p0_d     = x_p0_q;
      chan_p0_d  = chan_p0_q;
      alpha_p0_d = alpha_p0_q;
      byp_p0_d   = byp_p0_q;
      if (accept) begin
         x_p0_d     = x_data;
         chan_p0_d  = x_chan;
         alpha_p0_d = alpha_q;
         byp_p0_d   = bypass;
      end
      y_p1_d    = y_p1_q;
      chan_p1_d = chan_p1_q;
      if (advance) begin
         y_p1_d    = y_res;
         chan_p1_d = chan_p0_q;
      end
      // A clear on the same edge as a writeback to that channel takes priority
      for (int c = 0; c < CHANNELS; c++) begin
         state_d[c] = state_q[c];
         if (advance && chan_ok && chan_p0_q == CW'(c)) state_d[c] = y_res;
         if (clear_valid && clear_chan == CW'(c)) state_d[c] = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         alpha_q   <= clamp_alpha(W'(ALPHA_DEFAULT));
         vld_p0_q  <= 1'b0;
         vld_p1_q  <= 1'b0;
         y_p1_q    <= '0;
         chan_p1_q <= '0;
         for (int c = 0; c < CHANNELS; c++) state_q[c] <= '0;
      end else begin
         alpha_q   <= alpha_d;
         vld_p0_q  <= vld_p0_d;
         vld_p1_q  <= vld_p1_d;
         y_p1_q    <= y_p1_d;
         chan_p1_q <= chan_p1_d;
         for (int c = 0; c < CHANNELS; c++) state_q[c] <= state_d[c];
      end
   end

   // Stage A payload is qualified by vld_p0_q, so it needs no reset
   always_ff @(posedge clk) begin
      x_p0_q     <= x_p0_d;
      chan_p0_q  <= chan_p0_d;
      alpha_p0_q <= alpha_p0_d;
      byp_p0_q   <= byp_p0_d;
   end

   assign y_data  = y_p1_q;
   assign y_chan  = chan_p1_q;
   assign y_valid = vld_p1_q;

endmodule
